// File: rtl/lcd_read_driver_pkg.sv
// Shared definitions for the Spartan-3E character LCD drivers: timing defaults,
// command codes and the state encodings used by the read engine.
package lcd_read_driver_pkg;

  localparam int SETUP_CYC_DEF    = 2;
  localparam int E_HIGH_CYC_DEF   = 25;
  localparam int NIB_GAP_CYC_DEF  = 100;
  localparam int CMD_WAIT_CYC_DEF = 4000;

  localparam logic [7:0] SET_DDRAM_ADDR = 8'h80;

  typedef enum logic [3:0] {
    RD_IDLE,
    RD_AW_HI,
    RD_AW_LO,
    RD_TURN,
    RD_RW_SET,
    RD_RD_HI,
    RD_RD_LO,
    RD_RETURN,
    RD_DONE
  } rd_state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_EHI,
    PH_ELO
  } nib_phase_t;

  // Nibble of the set-DDRAM-address command for a given display position.
  function automatic logic [3:0] addr_nibble(input logic [6:0] pos, input logic hi);
    logic [7:0] cmd;
    cmd = SET_DDRAM_ADDR | {1'b0, pos};
    return hi ? cmd[7:4] : cmd[3:0];
  endfunction

endpackage

// File: rtl/lcd_read_driver_nibble_phase.sv
// One LCD nibble strobe: address/data setup, E high, then a runtime-selected E-low gap.
// sample marks the last E-high cycle; done marks the last gap cycle.
module lcd_nibble_phase
  import lcd_read_driver_pkg::*;
#(
  parameter int SETUP_CYC  = SETUP_CYC_DEF,
  parameter int E_HIGH_CYC = E_HIGH_CYC_DEF,
  parameter int CNT_W      = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] gap_cyc,
  output logic             e,
  output logic             sample,
  output logic             done
);

  nib_phase_t       phase_reg, phase_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_reg <= PH_IDLE;
      cnt_reg   <= '0;
    end else begin
      phase_reg <= phase_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    phase_next = phase_reg;
    cnt_next   = cnt_reg + CNT_W'(1);
    sample     = 1'b0;
    done       = 1'b0;
    case (phase_reg)
      PH_IDLE: begin
        cnt_next = '0;
        if (start) phase_next = PH_SETUP;
      end
      PH_SETUP: begin
        if (cnt_reg == CNT_W'(SETUP_CYC - 1)) begin
          phase_next = PH_EHI;
          cnt_next   = '0;
        end
      end
      PH_EHI: begin
        if (cnt_reg == CNT_W'(E_HIGH_CYC - 1)) begin
          sample     = 1'b1;
          phase_next = PH_ELO;
          cnt_next   = '0;
        end
      end
      PH_ELO: begin
        // A start on the final gap cycle chains straight into the next nibble.
        if (cnt_reg == gap_cyc - CNT_W'(1)) begin
          done       = 1'b1;
          cnt_next   = '0;
          phase_next = start ? PH_SETUP : PH_IDLE;
        end
      end
      default: begin
        phase_next = PH_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign e = (phase_reg == PH_EHI);

endmodule

// File: rtl/lcd_read_driver.sv
// Read-side LCD engine: busy-flag/address-counter read, or set-DDRAM-address
// followed by a character read, over the 4-bit SF_D<11:8> bus.
module lcd_read_driver
  import lcd_read_driver_pkg::*;
#(
  parameter int SETUP_CYC    = SETUP_CYC_DEF,
  parameter int E_HIGH_CYC   = E_HIGH_CYC_DEF,
  parameter int NIB_GAP_CYC  = NIB_GAP_CYC_DEF,
  parameter int CMD_WAIT_CYC = CMD_WAIT_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_read,
  input  logic       op_char,
  input  logic [6:0] dis_pos,
  input  logic [3:0] sf_d_in,
  output logic [3:0] sf_d_out,
  output logic       sf_d_oe,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       bus_own,
  output logic       ready,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       busy_flag
);

  localparam int CNT_W = $clog2(CMD_WAIT_CYC + 1);

  rd_state_t        state_reg, state_next;
  logic             op_reg, start_prev_reg, ready_reg, busy_flag_reg;
  logic [6:0]       pos_reg;
  logic [3:0]       hi_reg, lo_reg;
  logic [7:0]       rd_data_reg;
  logic             accept, nib_start, nib_sample, nib_done;
  logic [CNT_W-1:0] gap_cyc;

  // ready is only ever high while state_reg is IDLE.
  assign accept  = ready_reg && start_read && !start_prev_reg;
  assign gap_cyc = (state_reg == RD_AW_LO) ? CNT_W'(CMD_WAIT_CYC) : CNT_W'(NIB_GAP_CYC);

  lcd_nibble_phase #(
    .SETUP_CYC (SETUP_CYC),
    .E_HIGH_CYC(E_HIGH_CYC),
    .CNT_W     (CNT_W)
  ) u_nibble (
    .clk    (clk),
    .rst    (rst),
    .start  (nib_start),
    .gap_cyc(gap_cyc),
    .e      (lcd_e),
    .sample (nib_sample),
    .done   (nib_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= RD_IDLE;
      op_reg         <= 1'b0;
      pos_reg        <= '0;
      start_prev_reg <= 1'b0;
      ready_reg      <= 1'b0;
      hi_reg         <= '0;
      lo_reg         <= '0;
      rd_data_reg    <= '0;
      busy_flag_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      start_prev_reg <= start_read;
      ready_reg      <= (state_next == RD_IDLE);
      if (accept) begin
        op_reg  <= op_char;
        pos_reg <= dis_pos;
      end
      if (state_reg == RD_RD_HI && nib_sample) hi_reg <= sf_d_in;
      if (state_reg == RD_RD_LO && nib_sample) lo_reg <= sf_d_in;
      if (state_reg == RD_RETURN) begin
        rd_data_reg <= {hi_reg, lo_reg};
        if (!op_reg) busy_flag_reg <= hi_reg[3];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    nib_start  = 1'b0;
    sf_d_out   = 4'h0;
    sf_d_oe    = 1'b1;
    lcd_rs     = 1'b0;
    lcd_rw     = 1'b0;
    bus_own    = 1'b1;
    rd_valid   = 1'b0;
    case (state_reg)
      RD_IDLE: begin
        bus_own = 1'b0;
        if (accept) begin
          state_next = op_char ? RD_AW_HI : RD_TURN;
          nib_start  = op_char;
        end
      end
      RD_AW_HI: begin
        sf_d_out = addr_nibble(pos_reg, 1'b1);
        if (nib_done) begin
          state_next = RD_AW_LO;
          nib_start  = 1'b1;
        end
      end
      RD_AW_LO: begin
        sf_d_out = addr_nibble(pos_reg, 1'b0);
        if (nib_done) state_next = RD_TURN;
      end
      RD_TURN: begin
        // Release the bus a full cycle before the LCD is told to drive it.
        sf_d_oe    = 1'b0;
        state_next = RD_RW_SET;
      end
      RD_RW_SET: begin
        sf_d_oe    = 1'b0;
        lcd_rw     = 1'b1;
        lcd_rs     = op_reg;
        state_next = RD_RD_HI;
        nib_start  = 1'b1;
      end
      RD_RD_HI: begin
        sf_d_oe = 1'b0;
        lcd_rw  = 1'b1;
        lcd_rs  = op_reg;
        if (nib_done) begin
          state_next = RD_RD_LO;
          nib_start  = 1'b1;
        end
      end
      RD_RD_LO: begin
        sf_d_oe = 1'b0;
        lcd_rw  = 1'b1;
        lcd_rs  = op_reg;
        if (nib_done) state_next = RD_RETURN;
      end
      RD_RETURN: begin
        sf_d_oe    = 1'b0;
        lcd_rs     = op_reg;
        state_next = RD_DONE;
      end
      RD_DONE: begin
        bus_own    = 1'b0;
        rd_valid   = 1'b1;
        state_next = RD_IDLE;
      end
      default: state_next = RD_IDLE;
    endcase
  end

  assign ready     = ready_reg;
  assign rd_data   = rd_data_reg;
  assign busy_flag = busy_flag_reg;

endmodule
